fwd_hazard_ctrl: RTL
====================

Name: fwd_hazard_ctrl

Overview:
- Generates the select signals that drive the 4:1 32-bit operand forwarding muxes in the decode stage, plus the load-use interlock stall.
- Internally shadows the EXE and MEM stage destination and control bits in its own pipeline registers.
- Sits beside the decode stage. It consumes ID-stage register numbers and control bits, and produces fwda, fwdb and stall each cycle.

Parameters:
- RA_W, 5, register-number width.
- STAT_W, 32, width of the statistics counters (used only with FWD_STATS_EN).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  RA_W  source register A number
- id_rt  in  RA_W  source register B number
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt
- id_rn  in  RA_W  destination register (already muxed rd/rt)
- id_wreg  in  1  instruction writes the register file
- id_m2reg  in  1  instruction is a load (result comes from memory)
- flush  in  1  squash the ID instruction (taken branch/jump)
- fwda  out  2  operand A mux select
- fwdb  out  2  operand B mux select
- stall  out  1  hold PC and IF/ID, inject a bubble
- e_rn  out  RA_W  shadow EXE destination (debug)
- m_rn  out  RA_W  shadow MEM destination (debug)

Behaviour:
- Mux select encoding:
  - 00 = register file
  - 01 = EXE ALU result
  - 10 = MEM ALU result
  - 11 = MEM load data
- Shadow state:
  - EXE stage: ewreg, em2reg, ern.
  - MEM stage: mwreg, mm2reg, mrn.
  - Updated on the rising clock edge only.
- Reset (synchronous, reset=1 at the edge): all shadow bits and register numbers go to 0. Following that edge: fwda=fwdb=00, stall=0, e_rn=m_rn=0.
- Per-clock update when not in reset:
  - The MEM shadow always takes the EXE shadow.
  - The EXE shadow takes the ID fields when id_valid & !stall & !flush.
  - Otherwise the EXE shadow becomes a bubble: ewreg=em2reg=0, ern=0.
  - The EXE-side ewreg/em2reg are loaded as id_wreg&id_valid and id_m2reg&id_valid.
- fwda (combinational from current shadow state and ID inputs), evaluated in priority order:
  1. ewreg & !em2reg & ern!=0 & ern==id_rs -> 01.
  2. Else mwreg & mrn!=0 & mrn==id_rs -> 11 if mm2reg, else 10.
  3. Else 00.
- fwdb uses the same rules with id_rt.
- EXE match has priority over MEM match: the youngest producer wins.
- Register 0 never forwards and never stalls.
- stall = id_valid & ewreg & em2reg & ern!=0 & ((id_use_rs & ern==id_rs) | (id_use_rt & ern==id_rt)).
- stall is combinational, with zero-cycle latency from the ID inputs.
- Load-use sequence:
  - Cycle N: stall=1, bubble written into EXE.
  - Cycle N+1: the load sits in MEM, stall=0, select=11.
  - Exactly one stall cycle per load-use hazard.
- While stall=1, fwda/fwdb still reflect the rules above; the decode stage ignores them.
- flush and stall in the same cycle: a bubble is inserted; the flush has no extra effect.
- id_valid=0: no stall; selects are still computed but have no effect.
- Reset mid-stall: the shadow state is cleared, so stall drops on the cycle following the reset edge.
- No WB-stage forwarding: the register file writes in the first half-cycle and reads in the second.

Optional Feature:
- Macro: FWD_STATS_EN.
- When defined, adds two output ports:
  - stall_cnt (STAT_W): increments every cycle stall=1.
  - fwd_cnt (STAT_W): increments by 1 each cycle where fwda!=00 or fwdb!=00, with id_valid=1 and stall=0.
- Both counters clear on reset and saturate at all-ones (no wrap).
- When undefined, the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: hold reset 2 cycles, then id_rs=3 with no prior writes -> fwda=00, fwdb=00, stall=0, e_rn=m_rn=0.
- EXE forward:
  - Cycle 0: ALU op id_rn=5, wreg=1, m2reg=0.
  - Cycle 1: id_rs=5, id_rt=5.
  - Required: fwda=01, fwdb=01.
  - Cycle 2: an unrelated instruction; required fwda=10 when the rs=5 reader is presented in that cycle.
- Load-use:
  - Cycle 0: load id_rn=8, m2reg=1.
  - Cycle 1: id_rs=8, use_rs=1 -> stall=1.
  - Cycle 2: same ID held -> stall=0, fwda=11.
  - With FWD_STATS_EN: stall_cnt=1.
- Priority and r0:
  - Writes to r9 issued back-to-back (MEM and EXE both hold r9), then a reader of r9 -> fwda=01.
  - A writer to r0 followed by a reader of r0 -> fwda=00, no stall, even when the r0 writer is a load.
- Flush:
  - Load id_rn=4 presented with flush=1, then a reader of rs=4 -> stall=0, fwda=00.
  - The flushed instruction never reaches the MEM shadow.
- Saturation (FWD_STATS_EN, STAT_W forced to 4): hold a stall-inducing pattern for 20 cycles -> stall_cnt holds at 15.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// Decode-stage forwarding select generator and load-use interlock, shadowing EXE/MEM destinations.
// Optional build macro FWD_STATS_EN adds saturating stall_cnt / fwd_cnt statistics outputs.
module fwd_hazard_ctrl #(
    parameter int RA_W   = 5,
    parameter int STAT_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [RA_W-1:0]   id_rs,
    input  logic [RA_W-1:0]   id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [RA_W-1:0]   id_rn,
    input  logic              id_wreg,
    input  logic              id_m2reg,
    input  logic              flush,
    output logic [1:0]        fwda,
    output logic [1:0]        fwdb,
    output logic              stall,
    output logic [RA_W-1:0]   e_rn,
    output logic [RA_W-1:0]   m_rn
`ifdef FWD_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] fwd_cnt
`endif
);

    localparam logic [1:0]      SEL_RF      = 2'b00;
    localparam logic [1:0]      SEL_EXE     = 2'b01;
    localparam logic [1:0]      SEL_MEM_ALU = 2'b10;
    localparam logic [1:0]      SEL_MEM_LD  = 2'b11;
    localparam logic [RA_W-1:0] REG_ZERO    = '0;

    if (RA_W < 1 || STAT_W < 1) begin : g_bad_param
        $error("fwd_hazard_ctrl: RA_W and STAT_W must be positive");
    end

    logic            ewreg;
    logic            em2reg;
    logic [RA_W-1:0] ern;
    logic            mwreg;
    logic            mm2reg;
    logic [RA_W-1:0] mrn;
    logic            issue;
    logic            load_hit_rs;
    logic            load_hit_rt;

    // An EXE load has no result yet, so it falls through to the MEM check (and stalls).
    function automatic logic [1:0] pick_src(
        input logic [RA_W-1:0] src,
        input logic            ew,
        input logic            em,
        input logic [RA_W-1:0] er,
        input logic            mw,
        input logic            mm,
        input logic [RA_W-1:0] mr
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (ew && !em && er != REG_ZERO && er == src) begin
            sel = SEL_EXE;
        end else if (mw && mr != REG_ZERO && mr == src) begin
            sel = mm ? SEL_MEM_LD : SEL_MEM_ALU;
        end
        return sel;
    endfunction

    always_comb begin
        fwda        = pick_src(id_rs, ewreg, em2reg, ern, mwreg, mm2reg, mrn);
        fwdb        = pick_src(id_rt, ewreg, em2reg, ern, mwreg, mm2reg, mrn);
        load_hit_rs = id_use_rs && (ern == id_rs);
        load_hit_rt = id_use_rt && (ern == id_rt);
        stall       = id_valid && ewreg && em2reg && (ern != REG_ZERO)
                      && (load_hit_rs || load_hit_rt);
        issue       = id_valid && !stall && !flush;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ewreg  <= 1'b0;
            em2reg <= 1'b0;
            ern    <= '0;
            mwreg  <= 1'b0;
            mm2reg <= 1'b0;
            mrn    <= '0;
        end else begin
            mwreg  <= ewreg;
            mm2reg <= em2reg;
            mrn    <= ern;
            if (issue) begin
                ewreg  <= id_wreg;
                em2reg <= id_m2reg;
                ern    <= id_rn;
            end else begin
                ewreg  <= 1'b0;
                em2reg <= 1'b0;
                ern    <= '0;
            end
        end
    end

    assign e_rn = ern;
    assign m_rn = mrn;

`ifdef FWD_STATS_EN
    logic fwd_event;

    assign fwd_event = id_valid && !stall && (fwda != SEL_RF || fwdb != SEL_RF);

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && stall_cnt != {STAT_W{1'b1}}) begin
                stall_cnt <= stall_cnt + STAT_W'(1);
            end
            if (fwd_event && fwd_cnt != {STAT_W{1'b1}}) begin
                fwd_cnt <= fwd_cnt + STAT_W'(1);
            end
        end
    end
`endif

endmodule
